// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings and default timing for intersection_ctrl
package traffic_pkg;

  // Phase encodings; the numeric value is exported on the phase output.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PREEMPT   = 3'd6
  } state_t;

  // Width of the seconds timer and countdown output.
  localparam int TW = 6;

  // Default phase durations in seconds.
  localparam int DEF_T_GREEN  = 30;
  localparam int DEF_T_MIN    = 10;
  localparam int DEF_T_YELLOW = 5;
  localparam int DEF_T_ALLRED = 2;
  localparam int DEF_T_WALK   = 8;

  // Direction encoding used by emerg_dir and the preempt direction register.
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/intersection_ctrl_if.sv
// rtl/intersection_ctrl_if.sv - request inputs and lamp/status outputs of intersection_ctrl
interface intersection_ctrl_if;
  import traffic_pkg::*;

  logic          tick_1hz;
  logic          ped_ns;
  logic          ped_ew;
  logic          emerg;
  logic          emerg_dir;
  logic          ns_red;
  logic          ns_yellow;
  logic          ns_green;
  logic          ew_red;
  logic          ew_yellow;
  logic          ew_green;
  logic          walk_ns;
  logic          walk_ew;
  logic [TW-1:0] countdown;
  logic [2:0]    phase;

  // Requester side: drives tick, pedestrian and preempt requests.
  modport master (
    output tick_1hz, ped_ns, ped_ew, emerg, emerg_dir,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  walk_ns, walk_ew, countdown, phase
  );

  // Controller side.
  modport slave (
    input  tick_1hz, ped_ns, ped_ew, emerg, emerg_dir,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output walk_ns, walk_ew, countdown, phase
  );

endinterface

// File: rtl/ped_latch.sv
// rtl/ped_latch.sv - two-channel sticky pedestrian request latch, set wins over clear
module ped_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_set,
  input  logic [1:0] i_clr,
  output logic [1:0] o_pend
);

  logic [1:0] r_pend;

  // Hold each request until cleared; a set in the clearing clk keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= i_set | (r_pend & ~i_clr);
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - two-way intersection signal controller with pedestrian and preempt handling
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_MIN    = DEF_T_MIN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_WALK   = DEF_T_WALK
) (
  input  logic               clk,
  input  logic               rst,
  intersection_ctrl_if.slave ctl
);

  localparam logic [TW-1:0] L_ONE    = TW'(1);
  localparam logic [TW-1:0] L_GREEN  = TW'(T_GREEN);
  localparam logic [TW-1:0] L_YELLOW = TW'(T_YELLOW);
  localparam logic [TW-1:0] L_ALLRED = TW'(T_ALLRED);
  // A tick taken at or below this timer value brings elapsed green time up to T_MIN.
  localparam logic [TW-1:0] L_EARLY  = TW'(T_GREEN - T_MIN + 1);
  // Walk is lit while the timer is above this value, i.e. elapsed < T_WALK.
  localparam logic [TW-1:0] L_WALK   = TW'(T_GREEN - T_WALK);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_walk_ok;   // [0]=NS, [1]=EW: request was pending when green began
  logic          r_pre_dir;   // direction held green while in PREEMPT

  logic       w_expire;
  logic       w_enter_ns;
  logic       w_enter_ew;
  logic [1:0] w_pend;         // [0]=NS, [1]=EW
  logic       w_ns_green;
  logic       w_ew_green;

  assign w_expire   = ctl.tick_1hz && (r_timer <= L_ONE);
  // Greens are only entered from their all-red phase when no preempt is active.
  assign w_enter_ns = (r_state == ALLRED_B) && w_expire && !ctl.emerg;
  assign w_enter_ew = (r_state == ALLRED_A) && w_expire && !ctl.emerg;

  ped_latch u_ped_latch (
    .clk    (clk),
    .rst    (rst),
    .i_set  ({ctl.ped_ew, ctl.ped_ns}),
    .i_clr  ({w_enter_ew, w_enter_ns}),
    .o_pend (w_pend)
  );

  // Phase sequencing, timer, preempt handling and walk eligibility capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ALLRED_B;
      r_timer   <= L_ALLRED;
      r_walk_ok <= 2'b00;
      r_pre_dir <= DIR_NS;
    end else begin
      case (r_state)
        NS_GREEN: begin
          if (ctl.emerg && ctl.emerg_dir == DIR_NS) begin
            r_state   <= PREEMPT;
            r_pre_dir <= DIR_NS;
          end else if (ctl.emerg ||
                       w_expire ||
                       (ctl.tick_1hz && w_pend[1] && r_timer <= L_EARLY)) begin
            r_state <= NS_YELLOW;
            r_timer <= L_YELLOW;
          end else if (ctl.tick_1hz) begin
            r_timer <= r_timer - L_ONE;
          end
        end
        EW_GREEN: begin
          if (ctl.emerg && ctl.emerg_dir == DIR_EW) begin
            r_state   <= PREEMPT;
            r_pre_dir <= DIR_EW;
          end else if (ctl.emerg ||
                       w_expire ||
                       (ctl.tick_1hz && w_pend[0] && r_timer <= L_EARLY)) begin
            r_state <= EW_YELLOW;
            r_timer <= L_YELLOW;
          end else if (ctl.tick_1hz) begin
            r_timer <= r_timer - L_ONE;
          end
        end
        NS_YELLOW, EW_YELLOW: begin
          if (w_expire) begin
            r_state <= (r_state == NS_YELLOW) ? ALLRED_A : ALLRED_B;
            r_timer <= L_ALLRED;
          end else if (ctl.tick_1hz) begin
            r_timer <= r_timer - L_ONE;
          end
        end
        ALLRED_A, ALLRED_B: begin
          if (w_expire && ctl.emerg) begin
            r_state   <= PREEMPT;
            r_pre_dir <= ctl.emerg_dir;
          end else if (w_expire && r_state == ALLRED_A) begin
            r_state      <= EW_GREEN;
            r_timer      <= L_GREEN;
            r_walk_ok[1] <= w_pend[1];
          end else if (w_expire) begin
            r_state      <= NS_GREEN;
            r_timer      <= L_GREEN;
            r_walk_ok[0] <= w_pend[0];
          end else if (ctl.tick_1hz) begin
            r_timer <= r_timer - L_ONE;
          end
        end
        PREEMPT: begin
          // Timer is frozen; leave through the held direction's yellow on release or redirect.
          if (!ctl.emerg || ctl.emerg_dir != r_pre_dir) begin
            r_state <= (r_pre_dir == DIR_EW) ? EW_YELLOW : NS_YELLOW;
            r_timer <= L_YELLOW;
          end
        end
        default: begin
          r_state <= ALLRED_B;
          r_timer <= L_ALLRED;
        end
      endcase
    end
  end

  assign w_ns_green = (r_state == NS_GREEN) || (r_state == PREEMPT && r_pre_dir == DIR_NS);
  assign w_ew_green = (r_state == EW_GREEN) || (r_state == PREEMPT && r_pre_dir == DIR_EW);

  // Lamp and status decodes depend only on registered state.
  assign ctl.ns_green  = w_ns_green;
  assign ctl.ns_yellow = (r_state == NS_YELLOW);
  assign ctl.ns_red    = !w_ns_green && (r_state != NS_YELLOW);
  assign ctl.ew_green  = w_ew_green;
  assign ctl.ew_yellow = (r_state == EW_YELLOW);
  assign ctl.ew_red    = !w_ew_green && (r_state != EW_YELLOW);
  assign ctl.walk_ns   = (r_state == NS_GREEN) && r_walk_ok[0] && (r_timer > L_WALK);
  assign ctl.walk_ew   = (r_state == EW_GREEN) && r_walk_ok[1] && (r_timer > L_WALK);
  assign ctl.countdown = (r_state == PREEMPT) ? '0 : r_timer;
  assign ctl.phase     = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - self-checking bench for intersection_ctrl
module tb_intersection_ctrl;

  localparam logic [2:0] P_NSG = 3'd0;
  localparam logic [2:0] P_NSY = 3'd1;
  localparam logic [2:0] P_ARA = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_ARB = 3'd5;
  localparam logic [2:0] P_PRE = 3'd6;

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk_ns, walk_ew}
  localparam logic [7:0] LM_RED   = 8'b1001_0000;
  localparam logic [7:0] LM_NSG   = 8'b0011_0000;
  localparam logic [7:0] LM_NSG_W = 8'b0011_0010;
  localparam logic [7:0] LM_NSY   = 8'b0101_0000;
  localparam logic [7:0] LM_EWG   = 8'b1000_0100;
  localparam logic [7:0] LM_EWY   = 8'b1000_1000;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [5:0] cd;
    logic [7:0] lm;
  } exp_t;

  typedef struct {
    int         k;
    logic [2:0] ph;
    logic [5:0] cd;
    logic [7:0] lm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic emerg_lvl = 1'b0;
  logic dir_lvl = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[12];

  intersection_ctrl_if bus();

  intersection_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] act_lamps();
    return {bus.ns_red, bus.ns_yellow, bus.ns_green,
            bus.ew_red, bus.ew_yellow, bus.ew_green,
            bus.walk_ns, bus.walk_ew};
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clk: inputs applied at negedge, outputs sampled 1ns after posedge.
  task automatic cycle(input logic t, input logic pn, input logic pe);
    @(negedge clk);
    bus.tick_1hz  = t;
    bus.ped_ns    = pn;
    bus.ped_ew    = pe;
    bus.emerg     = emerg_lvl;
    bus.emerg_dir = dir_lvl;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.ped_ns   = 1'b0;
    bus.ped_ew   = 1'b0;
    chk("dual_green", int'(bus.ns_green & bus.ew_green), 0);
    chk("ns_one_lamp", int'(bus.ns_red) + int'(bus.ns_yellow) + int'(bus.ns_green), 1);
    chk("ew_one_lamp", int'(bus.ew_red) + int'(bus.ew_yellow) + int'(bus.ew_green), 1);
  endtask

  task automatic sb_push(input string tag, input logic [2:0] ph, input logic [5:0] cd,
                         input logic [7:0] lm);
    exp_t e;
    e.tag = tag;
    e.ph  = ph;
    e.cd  = cd;
    e.lm  = lm;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, "_phase"}, int'(bus.phase), int'(e.ph));
    chk({e.tag, "_countdown"}, int'(bus.countdown), int'(e.cd));
    chk({e.tag, "_lamps"}, int'(act_lamps()), int'(e.lm));
  endtask

  // n cycles with tick=t; the expectation is queued with the last one and checked after it.
  task automatic run_exp(input int n, input logic t, input string tag, input logic [2:0] ph,
                         input logic [5:0] cd, input logic [7:0] lm);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sb_push(tag, ph, cd, lm);
      cycle(t, 1'b0, 1'b0);
    end
    sb_check();
  endtask

  task automatic do_reset(input string tag);
    emerg_lvl = 1'b0;
    dir_lvl   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb_push(tag, P_ARB, 6'd2, LM_RED);
    cycle(1'b1, 1'b1, 1'b1);
    sb_check();
    chk({tag, "_pend"}, int'(dut.w_pend), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset raised between clock edges; outputs must follow before the next edge.
  task automatic async_rst(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb_push(tag, P_ARB, 6'd2, LM_RED);
    sb_check();
    chk({tag, "_pend"}, int'(dut.w_pend), 0);
    emerg_lvl     = 1'b0;
    dir_lvl       = 1'b0;
    bus.emerg     = 1'b0;
    bus.emerg_dir = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vi;
    bit hit;
    bus.tick_1hz  = 1'b0;
    bus.ped_ns    = 1'b0;
    bus.ped_ew    = 1'b0;
    bus.emerg     = 1'b0;
    bus.emerg_dir = 1'b0;

    vecs[0]  = '{1,   P_ARB, 6'd1,  LM_RED};
    vecs[1]  = '{2,   P_NSG, 6'd30, LM_NSG};
    vecs[2]  = '{10,  P_NSG, 6'd22, LM_NSG};
    vecs[3]  = '{31,  P_NSG, 6'd1,  LM_NSG};
    vecs[4]  = '{32,  P_NSY, 6'd5,  LM_NSY};
    vecs[5]  = '{37,  P_ARA, 6'd2,  LM_RED};
    vecs[6]  = '{38,  P_ARA, 6'd1,  LM_RED};
    vecs[7]  = '{39,  P_EWG, 6'd30, LM_EWG};
    vecs[8]  = '{69,  P_EWY, 6'd5,  LM_EWY};
    vecs[9]  = '{74,  P_ARB, 6'd2,  LM_RED};
    vecs[10] = '{76,  P_NSG, 6'd30, LM_NSG};
    vecs[11] = '{100, P_NSG, 6'd6,  LM_NSG};

    // Reset takes effect before any clock edge.
    #1;
    rst = 1'b1;
    #1;
    sb_push("por_async", P_ARB, 6'd2, LM_RED);
    sb_check();
    do_reset("por");

    // Normal cycle, 100 ticks, each followed by an idle clk that must not move the timer.
    vi = 0;
    for (int k = 1; k <= 100; k++) begin
      hit = (vi < 12) && (vecs[vi].k == k);
      if (hit) sb_push($sformatf("norm_t%0d", k), vecs[vi].ph, vecs[vi].cd, vecs[vi].lm);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      if (hit) begin
        sb_check();
        vi++;
      end
    end

    // Pedestrian NS request during EW green forces early end, then walk on NS.
    do_reset("ped");
    run_exp(39, 1'b1, "ped_ewg", P_EWG, 6'd30, LM_EWG);
    run_exp(3, 1'b1, "ped_el3", P_EWG, 6'd27, LM_EWG);
    chk("ped_pend_before", int'(dut.w_pend[0]), 0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("ped_pend_set", int'(dut.w_pend[0]), 1);
    run_exp(6, 1'b1, "ped_el9", P_EWG, 6'd21, LM_EWG);
    run_exp(1, 1'b1, "ped_early", P_EWY, 6'd5, LM_EWY);
    run_exp(5, 1'b1, "ped_arb", P_ARB, 6'd2, LM_RED);
    run_exp(2, 1'b1, "ped_nsg", P_NSG, 6'd30, LM_NSG_W);
    chk("ped_pend_clr", int'(dut.w_pend[0]), 0);
    for (int i = 1; i <= 7; i++) begin
      run_exp(1, 1'b1, $sformatf("ped_walk%0d", i), P_NSG, 6'(30 - i), LM_NSG_W);
    end
    run_exp(1, 1'b1, "ped_walk_end", P_NSG, 6'd22, LM_NSG);

    // Emergency toward EW while NS is green.
    do_reset("emg");
    run_exp(2, 1'b1, "emg_nsg", P_NSG, 6'd30, LM_NSG);
    run_exp(10, 1'b1, "emg_cd20", P_NSG, 6'd20, LM_NSG);
    emerg_lvl = 1'b1;
    dir_lvl   = 1'b1;
    run_exp(1, 1'b0, "emg_nsy", P_NSY, 6'd5, LM_NSY);
    run_exp(4, 1'b1, "emg_nsy1", P_NSY, 6'd1, LM_NSY);
    run_exp(1, 1'b1, "emg_ara", P_ARA, 6'd2, LM_RED);
    run_exp(1, 1'b1, "emg_ara1", P_ARA, 6'd1, LM_RED);
    run_exp(1, 1'b1, "emg_pre", P_PRE, 6'd0, LM_EWG);
    for (int i = 0; i < 10; i++) begin
      run_exp(1, 1'b1, $sformatf("emg_hold%0d", i), P_PRE, 6'd0, LM_EWG);
    end
    emerg_lvl = 1'b0;
    run_exp(1, 1'b0, "emg_drop", P_EWY, 6'd5, LM_EWY);
    run_exp(5, 1'b1, "emg_arb", P_ARB, 6'd2, LM_RED);
    run_exp(2, 1'b1, "emg_back", P_NSG, 6'd30, LM_NSG);

    // Preempt in the green direction, then redirect, then reset during PREEMPT.
    do_reset("dir");
    run_exp(2, 1'b1, "dir_nsg", P_NSG, 6'd30, LM_NSG);
    emerg_lvl = 1'b1;
    dir_lvl   = 1'b0;
    run_exp(1, 1'b0, "dir_pre_ns", P_PRE, 6'd0, LM_NSG);
    run_exp(3, 1'b1, "dir_hold", P_PRE, 6'd0, LM_NSG);
    dir_lvl = 1'b1;
    run_exp(1, 1'b0, "dir_nsy", P_NSY, 6'd5, LM_NSY);
    run_exp(5, 1'b1, "dir_ara", P_ARA, 6'd2, LM_RED);
    run_exp(2, 1'b1, "dir_pre_ew", P_PRE, 6'd0, LM_EWG);
    async_rst("dir_rst");
    run_exp(2, 1'b1, "dir_after", P_NSG, 6'd30, LM_NSG);

    // Request in the same clk as NS green entry stays pending and gives no walk.
    do_reset("sw");
    run_exp(1, 1'b1, "sw_arb1", P_ARB, 6'd1, LM_RED);
    sb_push("sw_nsg", P_NSG, 6'd30, LM_NSG);
    cycle(1'b1, 1'b1, 1'b0);
    sb_check();
    chk("sw_pend_kept", int'(dut.w_pend[0]), 1);
    run_exp(3, 1'b1, "sw_nsg27", P_NSG, 6'd27, LM_NSG);
    run_exp(27, 1'b1, "sw_nsy", P_NSY, 6'd5, LM_NSY);
    run_exp(5, 1'b1, "sw_ara", P_ARA, 6'd2, LM_RED);
    run_exp(2, 1'b1, "sw_ewg", P_EWG, 6'd30, LM_EWG);
    run_exp(10, 1'b1, "sw_early", P_EWY, 6'd5, LM_EWY);
    run_exp(2, 1'b1, "sw_ewy3", P_EWY, 6'd3, LM_EWY);
    async_rst("mid_ewy");
    run_exp(2, 1'b1, "post_rst", P_NSG, 6'd30, LM_NSG);

    if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameters: T_GREEN default 30, max green seconds; T_MIN default 10, min green before early termination; T_YELLOW default 5; T_ALLRED default 2, all-red clearance; T_WALK default 8, walk-signal seconds.
REQ-002 SHALL have ports:
- clk, in, 1, system clock; one clock domain
- rst, in, 1, reset, asynchronous, active-high
- tick_1hz, in, 1, one-clk pulse per second
- ped_ns, in, 1, pedestrian request to cross alongside NS traffic; one-clk pulse
- ped_ew, in, 1, same for EW
- emerg, in, 1, emergency preempt; level
- emerg_dir, in, 1, preempt direction; 0=NS, 1=EW
- ns_red/ns_yellow/ns_green, out, 1 each, NS lamps
- ew_red/ew_yellow/ew_green, out, 1 each, EW lamps
- walk_ns, walk_ew, out, 1 each, walk lamps
- countdown, out, 6, seconds left in current phase
- phase, out, 3, current state encoding

Function
REQ-003 SHALL implement states NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, PREEMPT.
REQ-004 SHALL run this normal cycle: NS_GREEN(T_GREEN) -> NS_YELLOW(T_YELLOW) -> ALLRED_A(T_ALLRED) -> EW_GREEN(T_GREEN) -> EW_YELLOW -> ALLRED_B -> NS_GREEN.
REQ-005 SHALL decrement the 6-bit timer only on tick_1hz; a tick with timer<=1 SHALL advance the state and load the next duration in that same clk.
REQ-006 SHALL make exactly one lamp per direction active: the green direction shows green, the yellow direction shows yellow, all other cases show red. Both directions SHALL be red in ALLRED_A/B.
REQ-007 SHALL set a sticky latch pend_ns on ped_ns (pend_ew on ped_ew). A latch SHALL clear on entry to its direction's GREEN state. A pulse arriving in that same clk SHALL win, so the latch stays set.
REQ-008 SHALL drive walk_ns during NS_GREEN while the elapsed time (T_GREEN-timer) is below T_WALK, but only if pend_ns was set at the moment of entry. walk_ew SHALL behave the same way. Walk SHALL never be asserted outside GREEN.
REQ-009 SHALL force early termination when the opposite latch is pending during a GREEN state and elapsed >= T_MIN. On the next tick the state SHALL go to that direction's YELLOW, irrespective of timer.
REQ-010 emerg SHALL be sampled every clk, with priority over REQ-004/009:
- green in the direction other than emerg_dir -> that YELLOW, timer=T_YELLOW, same clk
- YELLOW -> completes normally
- ALLRED -> completes normally, then enters PREEMPT
- green already in emerg_dir -> PREEMPT
REQ-011 In PREEMPT the emerg_dir lamp SHALL be green and the other direction red. walk SHALL be 0, countdown=0, and the timer SHALL be frozen.
REQ-012 On emerg deassert in PREEMPT, SHALL go to the emerg_dir YELLOW with timer=T_YELLOW. A change of emerg_dir during PREEMPT SHALL pass through YELLOW then ALLRED before the new direction goes green.
REQ-013 countdown SHALL equal timer in all states except PREEMPT.
REQ-014 Outputs SHALL be registered-state decodes, combinational from state/timer only, with no input-to-output paths.
REQ-015 No transition SHALL ever go green-to-green or green-to-red without passing through YELLOW and ALLRED.

Reset
REQ-016 While rst=1, SHALL hold state=ALLRED_B, timer=T_ALLRED, and clear both latches. Outputs SHALL be all red, walk 0, countdown=T_ALLRED, with no dependence on clk.
REQ-017 Reset asserted mid-phase (including PREEMPT) SHALL abort immediately to the REQ-016 values. After release, the first transition SHALL be into NS_GREEN.

Structure
REQ-018 SHALL place the state enum, phase encodings and default timing constants in a shared package, traffic_pkg.
REQ-019 SHALL instantiate one sub-module, ped_latch: a two-channel sticky request latch with set/clear and set-wins priority.

Verification
REQ-020 Reset release, no requests, 100 ticks:
- after 2 ticks -> NS_GREEN, countdown 30
- tick 32 -> NS_YELLOW
- tick 37 -> ALLRED_A
- tick 39 -> EW_GREEN
REQ-021 ped_ns at EW_GREEN elapsed 3:
- EW_YELLOW on the tick where elapsed reaches 10
- later NS_GREEN with walk_ns high for 8 ticks
- pend_ns cleared
REQ-022 emerg=1, emerg_dir=1 during NS_GREEN countdown 20:
- NS_YELLOW same clk, 5 ticks
- ALLRED_A, 2 ticks
- PREEMPT with ew_green=1
- hold 10 ticks, countdown 0
- drop emerg -> EW_YELLOW, countdown 5
REQ-023 ped_ns and NS_GREEN entry in the same clk -> pend_ns remains 1 and walk_ns=0 this phase.
REQ-024 rst pulse mid-EW_YELLOW -> all red, countdown 2 asynchronously. Every sampled cycle SHALL be checked for no simultaneous ns_green and ew_green.
